// File: rtl/als_pkg.sv
// rtl/als_pkg.sv - shared constants, FSM state and metrics bundle for the ALS error monitor
`timescale 1ns/1ps
package als_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int CNT_W_DEF = 20;
    localparam int ACC_W_DEF = WIDTH_DEF + 1 + CNT_W_DEF;
    localparam int SQ_W_DEF  = 2 * (WIDTH_DEF + 1) + CNT_W_DEF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } als_state_t;

    // Default-width view of the reported metrics; sq_sum is meaningful only with ALS_MSE_EN.
    typedef struct packed {
        logic [CNT_W_DEF-1:0] err_cnt;
        logic [ACC_W_DEF-1:0] ed_sum;
        logic [WIDTH_DEF:0]   ed_max;
        logic [SQ_W_DEF-1:0]  sq_sum;
    } als_metrics_t;

endpackage

// File: rtl/als_error_monitor_if.sv
// rtl/als_error_monitor_if.sv - operand/result beat stream between adder under test and monitor
`timescale 1ns/1ps
interface als_error_monitor_if
    import als_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic [WIDTH:0]   approx_out;

    modport master (
        output in_valid,
        output in0,
        output in1,
        output approx_out,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in0,
        input  in1,
        input  approx_out,
        output in_ready
    );

endinterface

// File: rtl/als_err_dist.sv
// rtl/als_err_dist.sv - S1/S2 datapath: exact sum, absolute error distance, optional square (ALS_MSE_EN)
`timescale 1ns/1ps
module als_err_dist
    import als_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     beat_valid,
    input  logic [WIDTH-1:0]         in0,
    input  logic [WIDTH-1:0]         in1,
    input  logic [WIDTH:0]           approx_out,
    output logic                     s1_valid,
    output logic                     ed_valid,
    output logic [WIDTH:0]           ed,
    output logic                     ed_nz
`ifdef ALS_MSE_EN
    ,
    output logic [2*(WIDTH+1)-1:0]   ed_sq
`endif
);

    logic [WIDTH:0] exact_q;
    logic [WIDTH:0] approx_q;
    logic [WIDTH:0] diff;

    // S1: the exact model lives here so a different operator only swaps this sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= beat_valid;
        end
        if (beat_valid) begin
            exact_q  <= {1'b0, in0} + {1'b0, in1};
            approx_q <= approx_out;
        end
    end

    always_comb begin
        diff = '0;
        if (approx_q >= exact_q) begin
            diff = approx_q - exact_q;
        end else begin
            diff = exact_q - approx_q;
        end
    end

    // S2
    always_ff @(posedge clk) begin
        if (rst) begin
            ed_valid <= 1'b0;
        end else begin
            ed_valid <= s1_valid;
        end
        if (s1_valid) begin
            ed    <= diff;
            ed_nz <= |diff;
`ifdef ALS_MSE_EN
            ed_sq <= {{(WIDTH+1){1'b0}}, diff} * {{(WIDTH+1){1'b0}}, diff};
`endif
        end
    end

endmodule

// File: rtl/als_error_monitor.sv
// rtl/als_error_monitor.sv - streaming error-metric accumulator for approximate adders; ALS_MSE_EN adds sq_sum
`timescale 1ns/1ps
module als_error_monitor
    import als_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int ACC_W = WIDTH + 1 + CNT_W
) (
    input  logic                          clk,
    input  logic                          rst,
    als_error_monitor_if.slave            stream,
    input  logic                          start,
    input  logic [CNT_W-1:0]              n_samples,
    output logic                          busy,
    output logic                          done,
    output logic [CNT_W-1:0]              sample_cnt,
    output logic [CNT_W-1:0]              err_cnt,
    output logic [ACC_W-1:0]              ed_sum,
    output logic [WIDTH:0]                ed_max
`ifdef ALS_MSE_EN
    ,
    output logic [2*(WIDTH+1)+CNT_W-1:0]  sq_sum
`endif
);

    als_state_t     state;
    als_state_t     state_next;
    logic [CNT_W-1:0] n_lat;
    logic           room;
    logic           last_beat;
    logic           accept;
    logic           clear;
    logic           done_set;
    logic           s1_valid;
    logic           ed_valid;
    logic [WIDTH:0] ed;
    logic           ed_nz;
`ifdef ALS_MSE_EN
    localparam int SQ_W = 2 * (WIDTH + 1) + CNT_W;
    logic [2*(WIDTH+1)-1:0] ed_sq;
`endif

    assign room      = (sample_cnt < n_lat);
    assign last_beat = (sample_cnt + CNT_W'(1)) == n_lat;
    assign accept    = stream.in_valid && stream.in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // in_ready derives from state and sample_cnt only, never from in_valid.
    always_comb begin
        state_next      = state;
        stream.in_ready = 1'b0;
        busy            = 1'b0;
        clear           = 1'b0;
        done_set        = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next = ST_RUN;
                    clear      = 1'b1;
                end
            end
            ST_RUN: begin
                busy            = 1'b1;
                stream.in_ready = room;
                if (stream.in_valid && room && last_beat) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (!s1_valid && !ed_valid) begin
                    state_next = ST_DONE;
                    done_set   = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done <= 1'b0;
        end else begin
            done <= done_set;
        end
    end

    als_err_dist #(
        .WIDTH (WIDTH)
    ) u_err_dist (
        .clk        (clk),
        .rst        (rst),
        .beat_valid (accept),
        .in0        (stream.in0),
        .in1        (stream.in1),
        .approx_out (stream.approx_out),
        .s1_valid   (s1_valid),
        .ed_valid   (ed_valid),
        .ed         (ed),
        .ed_nz      (ed_nz)
`ifdef ALS_MSE_EN
        ,
        .ed_sq      (ed_sq)
`endif
    );

    // S3: accumulators. The pipeline is always empty when clear fires.
    always_ff @(posedge clk) begin
        if (rst) begin
            n_lat      <= '0;
            sample_cnt <= '0;
            err_cnt    <= '0;
            ed_sum     <= '0;
            ed_max     <= '0;
`ifdef ALS_MSE_EN
            sq_sum     <= '0;
`endif
        end else if (clear) begin
            n_lat      <= (n_samples == '0) ? CNT_W'(1) : n_samples;
            sample_cnt <= '0;
            err_cnt    <= '0;
            ed_sum     <= '0;
            ed_max     <= '0;
`ifdef ALS_MSE_EN
            sq_sum     <= '0;
`endif
        end else begin
            if (accept) begin
                sample_cnt <= sample_cnt + CNT_W'(1);
            end
            if (ed_valid) begin
                err_cnt <= err_cnt + CNT_W'(ed_nz);
                ed_sum  <= ed_sum + ACC_W'(ed);
                if (ed > ed_max) begin
                    ed_max <= ed;
                end
`ifdef ALS_MSE_EN
                sq_sum  <= sq_sum + SQ_W'(ed_sq);
`endif
            end
        end
    end

endmodule

// File: tb/tb_als_error_monitor.sv
// tb/tb_als_error_monitor.sv - directed self-checking bench for als_error_monitor (ALS_MSE_EN aware)
`timescale 1ns/1ps
module tb_als_error_monitor;
    import als_pkg::*;

    localparam int WIDTH = WIDTH_DEF;
    localparam int CNT_W = CNT_W_DEF;
    localparam int ACC_W = ACC_W_DEF;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] n_samples = '0;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sample_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [ACC_W-1:0] ed_sum;
    logic [WIDTH:0]   ed_max;
`ifdef ALS_MSE_EN
    logic [SQ_W_DEF-1:0] sq_sum;
`endif

    als_error_monitor_if #(.WIDTH(WIDTH)) bus ();

    als_error_monitor #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W),
        .ACC_W (ACC_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stream     (bus),
        .start      (start),
        .n_samples  (n_samples),
        .busy       (busy),
        .done       (done),
        .sample_cnt (sample_cnt),
        .err_cnt    (err_cnt),
        .ed_sum     (ed_sum),
        .ed_max     (ed_max)
`ifdef ALS_MSE_EN
        ,
        .sq_sum     (sq_sum)
`endif
    );

    always #5 clk = ~clk;

    int n_chk    = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int last_acc = 0;
    als_metrics_t expm;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        #1;
        if (done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic check_metrics(input string tag);
        chk({tag, "_err_cnt"}, 64'(err_cnt), 64'(expm.err_cnt));
        chk({tag, "_ed_sum"},  64'(ed_sum),  64'(expm.ed_sum));
        chk({tag, "_ed_max"},  64'(ed_max),  64'(expm.ed_max));
`ifdef ALS_MSE_EN
        chk({tag, "_sq_sum"},  64'(sq_sum),  64'(expm.sq_sum));
`endif
    endtask

    task automatic model_beat(input logic [15:0] a, input logic [15:0] b, input logic [16:0] ap);
        longint ex, d;
        ex = longint'(a) + longint'(b);
        d  = (longint'(ap) > ex) ? longint'(ap) - ex : ex - longint'(ap);
        if (d != 0) expm.err_cnt = expm.err_cnt + 1'b1;
        expm.ed_sum = expm.ed_sum + ACC_W'(d);
        if (d > longint'(expm.ed_max)) expm.ed_max = 17'(d);
        expm.sq_sum = expm.sq_sum + SQ_W_DEF'(d * d);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_beat(input logic [15:0] a, input logic [15:0] b, input logic [16:0] ap);
        int t = 0;
        bus.in_valid   = 1'b1;
        bus.in0        = a;
        bus.in1        = b;
        bus.approx_out = ap;
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            chk("ready_timeout", 64'(bus.in_ready), 64'd1);
        end else begin
            last_acc = cyc + 1;
            model_beat(a, b, ap);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic start_run(input string tag, input int n);
        start     = 1'b1;
        n_samples = CNT_W'(n);
        @(negedge clk);
        start = 1'b0;
        expm  = '0;
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        chk({tag, "_cnt_clr"}, 64'(sample_cnt), 64'd0);
        check_metrics({tag, "_clr"});
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (done !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_done_seen"}, 64'(done), 64'd1);
        chk({tag, "_done_lat"}, 64'(cyc - last_acc), 64'd3);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
        chk({tag, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [15:0] a, b;
        logic [16:0] s;
        int acc, dc;

        bus.in_valid   = 1'b0;
        bus.in0        = '0;
        bus.in1        = '0;
        bus.approx_out = '0;
        expm           = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sample_cnt", 64'(sample_cnt), 64'd0);
        check_metrics("rst");
        rst = 1'b0;
        @(negedge clk);

        // Exact adder, N=16, with an ignored start in the middle of the run.
        start_run("exact", 16);
        for (int i = 0; i < 16; i++) begin
            if (i == 8) begin
                start     = 1'b1;
                n_samples = CNT_W'(3);
                @(negedge clk);
                start = 1'b0;
            end
            a = 16'($urandom);
            b = 16'($urandom);
            s = {1'b0, a} + {1'b0, b};
            send_beat(a, b, s);
        end
        chk("exact_ready_low", 64'(bus.in_ready), 64'd0);
        chk("exact_drain_busy", 64'(busy), 64'd1);
        wait_done("exact");
        chk("exact_samples", 64'(sample_cnt), 64'd16);
        chk("exact_err_const", 64'(err_cnt), 64'd0);
        chk("exact_max_const", 64'(ed_max), 64'd0);
        check_metrics("exact");

        // Extremes, N=1
        start_run("ext", 1);
        send_beat(16'hFFFF, 16'hFFFF, 17'h00000);
        wait_done("ext");
        chk("ext_ed_max", 64'(ed_max), 64'h1FFFE);
        chk("ext_ed_sum", 64'(ed_sum), 64'h1FFFE);
`ifdef ALS_MSE_EN
        chk("ext_sq_sum", 64'(sq_sum), 64'h3FFF80004);
`endif

        // Known errors, restarted from DONE (clears previous metrics).
        start_run("known", 3);
        send_beat(16'h0001, 16'h0001, 17'h00003);
        send_beat(16'hFFFF, 16'h0001, 17'h0FFFF);
        send_beat(16'h0005, 16'h0005, 17'h0000A);
        wait_done("known");
        chk("known_err_cnt", 64'(err_cnt), 64'd2);
        chk("known_ed_sum", 64'(ed_sum), 64'd2);
        chk("known_ed_max", 64'(ed_max), 64'd1);
`ifdef ALS_MSE_EN
        chk("known_sq_sum", 64'(sq_sum), 64'd2);
`endif

        // n_samples = 0 runs a single beat.
        start_run("n0", 0);
        send_beat(16'd7, 16'd8, 17'h10);
        chk("n0_ready_low", 64'(bus.in_ready), 64'd0);
        wait_done("n0");
        chk("n0_samples", 64'(sample_cnt), 64'd1);
        chk("n0_err_cnt", 64'(err_cnt), 64'd1);

        // Random valid toggling with erroneous results, N=100.
        start_run("bp", 100);
        dc  = done_cnt;
        acc = 0;
        for (int t = 0; t < 2000 && acc < 100; t++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            s = {1'b0, a} + {1'b0, b};
            case ($urandom % 4)
                0: s = s;
                1: s = s + 17'd5;
                2: s = s - 17'd3;
                default: s = s ^ 17'h10;
            endcase
            bus.in_valid   = 1'($urandom % 2);
            bus.in0        = a;
            bus.in1        = b;
            bus.approx_out = s;
            if (bus.in_valid && bus.in_ready) begin
                model_beat(a, b, s);
                acc++;
            end
            @(negedge clk);
        end
        chk("bp_accepts", 64'(acc), 64'd100);
        chk("bp_ready_low", 64'(bus.in_ready), 64'd0);
        bus.in_valid = 1'b1;
        repeat (10) @(negedge clk);
        bus.in_valid = 1'b0;
        chk("bp_samples", 64'(sample_cnt), 64'd100);
        chk("bp_one_done", 64'(done_cnt - dc), 64'd1);
        check_metrics("bp");

        // Reset after 50 of 100 beats.
        start_run("rm", 100);
        for (int i = 0; i < 50; i++) begin
            send_beat(16'(i), 16'(i), 17'(2 * i + 1));
        end
        dc           = done_cnt;
        bus.in_valid = 1'b1;
        rst          = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst          = 1'b0;
        expm         = '0;
        chk("rm_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rm_busy", 64'(busy), 64'd0);
        chk("rm_samples", 64'(sample_cnt), 64'd0);
        check_metrics("rm");
        repeat (10) @(negedge clk);
        chk("rm_no_done", 64'(done_cnt - dc), 64'd0);
        chk("rm_err_hold", 64'(err_cnt), 64'd0);
        start_run("fresh", 2);
        send_beat(16'd3, 16'd4, 17'd8);
        send_beat(16'd100, 16'd200, 17'd300);
        wait_done("fresh");
        chk("fresh_err_cnt", 64'(err_cnt), 64'd1);
        chk("fresh_ed_sum", 64'(ed_sum), 64'd1);
        check_metrics("fresh");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
